// File: rtl/arr_seq_pkg.sv
// Shared definitions for the array-kernel run sequencer: default geometry and the run-state encoding.
package arr_seq_pkg;

  localparam int ARR_ADDR_W  = 10;
  localparam int ARR_DATA_W  = 64;
  localparam int ARR_DEPTH   = 1000;
  localparam int ARR_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/arr_seq_skid_fifo.sv
// Two-entry output FIFO that absorbs array read latency so drain backpressure never drops or reorders words.
module arr_seq_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem0_r;
  logic [W-1:0] mem1_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   cnt_r;
  logic         push_s;
  logic         pop_s;

  assign push_ready = (cnt_r != 2'd2);
  assign pop_valid  = (cnt_r != 2'd0);
  assign pop_data   = rd_ptr_r ? mem1_r : mem0_r;
  assign count      = cnt_r;
  assign pop_s      = pop_valid && pop_ready;
  // A full FIFO may still take a push in the same cycle it releases its head.
  assign push_s     = push_valid && (push_ready || pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_r   <= '0;
      mem1_r   <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        if (wr_ptr_r) mem1_r <= push_data;
        else          mem0_r <= push_data;
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/arr_kernel_sequencer.sv
// Run controller for one kernel instance: loads the array through the override port, starts the kernel,
// waits for done (or times out), then drains the array back out through a 2-entry FIFO.
module arr_kernel_sequencer
  import arr_seq_pkg::*;
#(
  parameter int ADDR_W  = ARR_ADDR_W,
  parameter int DATA_W  = ARR_DATA_W,
  parameter int DEPTH   = ARR_DEPTH,
  parameter int TIMEOUT = ARR_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [ADDR_W-1:0] cmd_init_i,
  input  logic [DATA_W-1:0] cmd_init_acc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              err_timeout,
  output logic              result_q,
  output logic              busy,
  output logic              k_r_enable,
  output logic              k_controlArr,
  output logic [ADDR_W-1:0] k_init_i,
  output logic [DATA_W-1:0] k_init_acc,
  output logic              k_we,
  output logic [ADDR_W-1:0] k_addr,
  output logic [DATA_W-1:0] k_wdata,
  input  logic [DATA_W-1:0] k_rdata,
  input  logic              k_w_enable,
  input  logic              k_result
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L    = (ADDR_W + 1)'(1);

  seq_state_e        state_r, state_nx_s;
  logic [ADDR_W:0]   len_r, cnt_r, len_sat_s, last_idx_s;
  logic [ADDR_W-1:0] init_i_r;
  logic [DATA_W-1:0] init_acc_r;
  logic              err_r, result_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              inflight_r, inflight_last_r;
  logic              issue_s, room_s, pop_s;
  logic              fifo_push_ready_s, fifo_pop_valid_s;
  logic [DATA_W:0]   fifo_pop_data_s;
  logic [1:0]        fifo_cnt_s;

  assign len_sat_s  = (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;
  assign last_idx_s = len_r - ONE_L;
  assign pop_s      = fifo_pop_valid_s && out_ready;
  // Credit counts the read in flight and the head leaving this cycle, giving 1 word/cycle at full rate.
  assign room_s     = inflight_r ? ((fifo_cnt_s == 2'd0) || ((fifo_cnt_s == 2'd1) && pop_s))
                                 : (fifo_push_ready_s || pop_s);

  assign out_valid   = fifo_pop_valid_s;
  assign out_data    = fifo_pop_data_s[DATA_W-1:0];
  assign out_last    = fifo_pop_valid_s && fifo_pop_data_s[DATA_W];
  assign busy        = (state_r != ST_IDLE);
  assign err_timeout = err_r;
  assign result_q    = result_r;
  assign k_init_i    = init_i_r;
  assign k_init_acc  = init_acc_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state decode and per-state port drive.
  always_comb begin
    state_nx_s   = state_r;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    k_r_enable   = 1'b0;
    k_controlArr = 1'b1;
    k_we         = 1'b0;
    k_addr       = '0;
    k_wdata      = '0;
    done         = 1'b0;
    issue_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx_s = (len_sat_s == '0) ? ST_START : ST_LOAD;
        else           state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          k_we    = 1'b1;
          k_addr  = cnt_r[ADDR_W-1:0];
          k_wdata = in_data;
          if (cnt_r == last_idx_s) state_nx_s = ST_START;
          else                     state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_START: begin
        k_r_enable   = 1'b1;
        k_controlArr = 1'b0;
        state_nx_s   = ST_RUN;
      end
      ST_RUN: begin
        k_controlArr = 1'b0;
        if (k_w_enable)             state_nx_s = (len_r == '0) ? ST_FIN : ST_DRAIN;
        else if (tmo_r == TMO_LAST) state_nx_s = ST_FIN;
        else                        state_nx_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((cnt_r < len_r) && room_s) begin
          issue_s = 1'b1;
          k_addr  = cnt_r[ADDR_W-1:0];
        end else begin
          issue_s = 1'b0;
        end
        if (pop_s && fifo_pop_data_s[DATA_W]) state_nx_s = ST_FIN;
        else                                  state_nx_s = ST_DRAIN;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Run datapath: command latch, address counter, run watchdog, read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r           <= '0;
      cnt_r           <= '0;
      init_i_r        <= '0;
      init_acc_r      <= '0;
      err_r           <= 1'b0;
      result_r        <= 1'b0;
      tmo_r           <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (cnt_r == last_idx_s);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_r      <= len_sat_s;
            init_i_r   <= cmd_init_i;
            init_acc_r <= cmd_init_acc;
            err_r      <= 1'b0;
            cnt_r      <= '0;
          end
        end
        ST_LOAD:  if (in_valid) cnt_r <= cnt_r + ONE_L;
        ST_START: tmo_r <= '0;
        ST_RUN: begin
          tmo_r <= tmo_r + TMO_W'(1);
          if (k_w_enable) begin
            result_r <= k_result;
            cnt_r    <= '0;
          end else if (tmo_r == TMO_LAST) begin
            err_r <= 1'b1;
          end
        end
        ST_DRAIN: if (issue_s) cnt_r <= cnt_r + ONE_L;
        default:  cnt_r <= cnt_r;
      endcase
    end
  end

  arr_seq_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (inflight_r),
    .push_ready (fifo_push_ready_s),
    .push_data  ({inflight_last_r, k_rdata}),
    .pop_valid  (fifo_pop_valid_s),
    .pop_ready  (out_ready),
    .pop_data   (fifo_pop_data_s),
    .count      (fifo_cnt_s)
  );

endmodule

// File: tb/tb_arr_kernel_sequencer.sv
// Directed/randomized bench for arr_kernel_sequencer with a behavioural array and identity-kernel model.
module tb_arr_kernel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_len = '0;
  logic [9:0]  cmd_init_i = '0;
  logic [63:0] cmd_init_acc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last, done, err_timeout, result_q, busy;
  logic        k_r_enable, k_controlArr, k_we;
  logic [9:0]  k_init_i, k_addr;
  logic [63:0] k_init_acc, k_wdata;
  logic [63:0] k_rdata = '0;
  logic        k_w_enable = 1'b0;
  logic        k_result = 1'b0;

  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

  arr_kernel_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_init_i(cmd_init_i), .cmd_init_acc(cmd_init_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err_timeout(err_timeout), .result_q(result_q), .busy(busy),
    .k_r_enable(k_r_enable), .k_controlArr(k_controlArr),
    .k_init_i(k_init_i), .k_init_acc(k_init_acc),
    .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata), .k_rdata(k_rdata),
    .k_w_enable(k_w_enable), .k_result(k_result)
  );

  always #5 clk = ~clk;

  // Array: single port, registered read, written only through the override port (identity kernel).
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (k_we) mem[k_addr] <= k_wdata;
    k_rdata <= mem[k_addr];
  end

  // Kernel: raises done 10 cycles after start and holds it until the next start.
  int   kcnt = 0;
  logic kernel_hang = 1'b0;
  logic kres = 1'b0;
  always @(posedge clk) begin
    if (k_r_enable) begin
      kcnt       <= 1;
      k_w_enable <= 1'b0;
    end else if (kcnt != 0 && kcnt < 10) begin
      kcnt <= kcnt + 1;
      if (kcnt == 9 && !kernel_hang) begin
        k_w_enable <= 1'b1;
        k_result   <= kres;
      end
    end
  end

  // Event log sampled mid-cycle.
  logic [9:0]  wa_q[$];
  logic [63:0] wd_q[$];
  logic [63:0] od_q[$];
  logic        ol_q[$];
  int ren_cnt = 0, done_cnt = 0, inrdy_cnt = 0, ov_cnt = 0, stab_err = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] data_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (k_we) begin
        wa_q.push_back(k_addr);
        wd_q.push_back(k_wdata);
      end
      if (k_r_enable) ren_cnt <= ren_cnt + 1;
      if (done)       done_cnt <= done_cnt + 1;
      if (in_ready)   inrdy_cnt <= inrdy_cnt + 1;
      if (out_valid)  ov_cnt <= ov_cnt + 1;
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        ol_q.push_back(out_last);
      end
      if (stall_prev && (!out_valid || out_data !== data_prev)) stab_err <= stab_err + 1;
      stall_prev <= out_valid && !out_ready;
      data_prev  <= out_data;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  logic [63:0] exp_q[$];
  logic [5:0]  rdy_pat = 6'b101001;  // 1,0,0,1,0,1 read from bit 0 upward

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_cmd(input int clen);
    logic [9:0]  ii;
    logic [63:0] ia;
    ii = 10'($urandom);
    ia = {$urandom, $urandom};
    cmd_len = 11'(clen); cmd_init_i = ii; cmd_init_acc = ia;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1'b1);
    chk("err_cleared_on_cmd", err_timeout, 1'b0);
    chk("init_scalars", {k_init_i, k_init_acc[31:0]}, {ii, ia[31:0]});
  endtask

  task automatic load_words(input int n);
    bit acc;
    bit ok;
    int spin;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      spin = 0;
      while (!acc && spin < 100) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = exp_q[i];
        acc      = in_valid && in_ready;
        @(posedge clk); #1;
        spin++;
      end
      if (!acc) ok = 1'b0;
    end
    in_valid = 1'b0;
    if (n > 0) chk("load_bound", ok, 1'b1);
  endtask

  task automatic do_run(input int clen, input int rmode, input bit hang, input bit fixed);
    int n, wb, ob, ren0, done0, inr0, ov0, stab0, cyc, pi, bad, badl, tmo_at;
    bit seen, tmo_done;
    n = (clen > 1000) ? 1000 : clen;
    if (!fixed) begin
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back({$urandom, $urandom});
    end
    kres = 1'($urandom_range(0, 1));
    kernel_hang = hang;
    wb = wa_q.size(); ob = od_q.size();
    ren0 = ren_cnt; done0 = done_cnt; inr0 = inrdy_cnt; ov0 = ov_cnt; stab0 = stab_err;
    send_cmd(clen);
    load_words(n);
    cyc = 0; pi = 0; seen = 1'b0; tmo_at = -1; tmo_done = 1'b0;
    while (busy && cyc < 6000) begin
      if (out_valid) seen = 1'b1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = seen ? rdy_pat[pi % 6] : 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (seen) pi++;
      @(posedge clk); #1;
      cyc++;
      if (err_timeout && tmo_at < 0) begin
        tmo_at = cyc;
        tmo_done = done;
      end
    end
    out_ready = 1'b0;
    chk("run_ends", busy, 1'b0);
    chk("wr_count", wa_q.size() - wb, n);
    bad = 0;
    for (int i = 0; i < n && wb + i < wa_q.size(); i++)
      if (wa_q[wb + i] != 10'(i) || wd_q[wb + i] !== exp_q[i]) bad++;
    chk("wr_addr_data", bad, 0);
    if (n == 1000) chk("wr_last_addr", wa_q[wa_q.size() - 1], 10'd999);
    chk("start_pulses", ren_cnt - ren0, 1);
    chk("done_pulses", done_cnt - done0, 1);
    if (n == 0) chk("no_in_ready", inrdy_cnt - inr0, 0);
    if (hang) begin
      chk("err_timeout_set", err_timeout, 1'b1);
      chk("timeout_cycle", tmo_at, 17);
      chk("timeout_with_done", tmo_done, 1'b1);
      chk("no_out_on_timeout", ov_cnt - ov0, 0);
    end else begin
      chk("no_err", err_timeout, 1'b0);
      chk("result_q", result_q, kres);
      chk("out_count", od_q.size() - ob, n);
      bad = 0; badl = 0;
      for (int i = 0; i < n && ob + i < od_q.size(); i++) begin
        if (od_q[ob + i] !== exp_q[i]) bad++;
        if (ol_q[ob + i] !== (i == n - 1)) badl++;
      end
      chk("out_data", bad, 0);
      chk("out_last", badl, 0);
      chk("out_stable", stab_err - stab0, 0);
      if (n == 0) chk("no_out_valid", ov_cnt - ov0, 0);
    end
  endtask

  initial begin
    int ob, done0, spin;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", {k_controlArr, k_r_enable, k_we, in_ready}, 4'b1000);
    chk("rst_outs", {out_valid, done, err_timeout, result_q}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_q.delete();
    exp_q.push_back(64'sd5); exp_q.push_back(-64'sd3);
    exp_q.push_back(64'sd7); exp_q.push_back(64'sd1);
    do_run(4, 0, 1'b0, 1'b1);
    do_run(3, 1, 1'b0, 1'b0);
    do_run(0, 0, 1'b0, 1'b0);
    do_run(0, 0, 1'b1, 1'b0);
    do_run(2, 2, 1'b0, 1'b0);

    // Reset mid-drain after two of five words.
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({$urandom, $urandom});
    kernel_hang = 1'b0;
    ob = od_q.size(); done0 = done_cnt;
    send_cmd(5);
    load_words(5);
    spin = 0;
    while (od_q.size() - ob < 2 && spin < 200) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      spin++;
    end
    chk("pre_reset_words", od_q.size() - ob, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_idle", {busy, cmd_ready}, 2'b01);
    chk("arst_outs", {out_valid, k_controlArr, k_we, done}, 4'b0100);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_done", done_cnt - done0, 0);
    do_run(6, 2, 1'b0, 1'b0);

    do_run(1023, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) do_run($urandom_range(1, 20), 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
